// File: rtl/de_scoreboard.sv
// Decode-stage register hazard scoreboard: a per-register count of outstanding writes, source/destination stalls and a total.
// Optional SB_WB_BYPASS_EN: a same-cycle writeback releases the hazard or saturation stall at once.
module de_scoreboard #(
    parameter int NREGS     = 32,
    parameter int REGNOBITS = $clog2(NREGS),
    parameter int CNT_BITS  = 2,
    parameter int NUM_RD    = 2,
    parameter int NUM_WB    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_RD-1:0]             rd_use,
    input  logic [NUM_RD*REGNOBITS-1:0]   rd_regno,
    input  logic                          issue_valid,
    input  logic [REGNOBITS-1:0]          issue_regno,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB*REGNOBITS-1:0]   wb_regno,
    output logic                          hazard,
    output logic                          sat_stall,
    output logic                          stall,
    output logic                          issue_fire,
    output logic [NREGS-1:0]              pending,
    output logic [REGNOBITS+CNT_BITS-1:0] outstanding,
    output logic                          underflow_err
);

    localparam int DW = $clog2(NUM_WB + 1);
    localparam int SW = CNT_BITS + DW;
    localparam int OW = REGNOBITS + CNT_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
`ifdef SB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [CNT_BITS-1:0] cnt_q [NREGS];
    logic [CNT_BITS-1:0] cnt_d [NREGS];
    logic [DW-1:0]       dec_cnt [NREGS];
    logic [NREGS-1:0]    released;
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    full;
    logic [OW-1:0]       out_q, out_d;
    logic                uf_q, uf_d;
    logic                inc_v;
    logic [SW-1:0]       sum_v;

    // Register 0 is never counted, so its releases and its busy/full flags stay inert.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            dec_cnt[r] = '0;
            for (int j = 0; j < NUM_WB; j++) begin
                if (r != 0 && wb_valid[j] && wb_regno[j*REGNOBITS +: REGNOBITS] == REGNOBITS'(r))
                    dec_cnt[r] = dec_cnt[r] + DW'(1);
            end
            released[r] = (dec_cnt[r] != '0);
            busy[r]     = (cnt_q[r] != '0) && !(BYPASS && cnt_q[r] == CNT_BITS'(1) && released[r]);
            full[r]     = (cnt_q[r] == CNT_MAX) && !(BYPASS && released[r]);
            pending[r]  = (r != 0) && (cnt_q[r] != '0);
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_use[i] && busy[rd_regno[i*REGNOBITS +: REGNOBITS]])
                hazard = 1'b1;
        end
        sat_stall  = issue_valid && full[issue_regno];
        stall      = hazard | sat_stall;
        issue_fire = issue_valid & ~stall;
    end

    // The total follows the counters by adding each register's net change, so clamped releases are not counted.
    always_comb begin
        uf_d  = uf_q;
        out_d = out_q;
        inc_v = 1'b0;
        sum_v = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc_v    = issue_fire && (issue_regno == REGNOBITS'(r)) && (r != 0);
            sum_v    = SW'(cnt_q[r]) + SW'(inc_v);
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (sum_v < SW'(dec_cnt[r])) begin
                    cnt_d[r] = '0;
                    uf_d     = 1'b1;
                end else begin
                    cnt_d[r] = CNT_BITS'(sum_v - SW'(dec_cnt[r]));
                end
            end
            out_d = out_d + OW'(cnt_d[r]) - OW'(cnt_q[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            out_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            out_q <= out_d;
            uf_q  <= uf_d;
        end
    end

    assign outstanding   = out_q;
    assign underflow_err = uf_q;

endmodule

// File: tb/tb_de_scoreboard.sv
// Randomized bench for de_scoreboard against a per-register count model, plus directed literal checks.
module tb_de_scoreboard;

    localparam int NREGS = 32;
    localparam int RB    = 5;
    localparam int CMAX  = 3;
`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    rd_use = '0;
    logic [9:0]    rd_regno = '0;
    logic          issue_valid = 1'b0;
    logic [4:0]    issue_regno = '0;
    logic [0:0]    wb_valid = '0;
    logic [4:0]    wb_regno = '0;
    logic          hazard, sat_stall, stall, issue_fire, underflow_err;
    logic [31:0]   pending;
    logic [6:0]    outstanding;

    de_scoreboard dut (
        .clk(clk), .reset(reset), .rd_use(rd_use), .rd_regno(rd_regno),
        .issue_valid(issue_valid), .issue_regno(issue_regno),
        .wb_valid(wb_valid), .wb_regno(wb_regno),
        .hazard(hazard), .sat_stall(sat_stall), .stall(stall), .issue_fire(issue_fire),
        .pending(pending), .outstanding(outstanding), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int cnt_m [NREGS];
    bit uf_m;
    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int rel_m(int r);
        if (r == 0) return 0;
        return (wb_valid[0] && int'(wb_regno) == r) ? 1 : 0;
    endfunction

    function automatic bit hz_m();
        for (int i = 0; i < 2; i++) begin
            int rr;
            rr = int'(rd_regno[i*RB +: RB]);
            if (rd_use[i] && rr != 0 && cnt_m[rr] != 0 && !(BYP && cnt_m[rr] == 1 && rel_m(rr) > 0))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit sat_m();
        int ir;
        ir = int'(issue_regno);
        return issue_valid && ir != 0 && cnt_m[ir] == CMAX && !(BYP && rel_m(ir) > 0);
    endfunction

    function automatic bit fire_m();
        return issue_valid && !(hz_m() || sat_m());
    endfunction

    always @(negedge reset) begin
        for (int r = 0; r < NREGS; r++) cnt_m[r] = 0;
        uf_m = 1'b0;
    end

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            bit f;
            f = fire_m();
            for (int r = 1; r < NREGS; r++) begin
                int v;
                v = cnt_m[r] + ((f && int'(issue_regno) == r) ? 1 : 0) - rel_m(r);
                if (v < 0) begin
                    v = 0;
                    uf_m = 1'b1;
                end
                cnt_m[r] = v;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            logic [31:0] pend_e;
            int sum;
            bit h, s;
            sum = 0;
            for (int r = 0; r < NREGS; r++) begin
                pend_e[r] = (r != 0) && (cnt_m[r] != 0);
                sum += cnt_m[r];
            end
            h = hz_m();
            s = sat_m();
            chk("hazard", hazard, h);
            chk("sat_stall", sat_stall, s);
            chk("stall", stall, h | s);
            chk("issue_fire", issue_fire, issue_valid && !(h || s));
            chk("pending", pending, pend_e);
            chk("outstanding", outstanding, sum);
            chk("underflow_err", underflow_err, uf_m);
        end
    end

    task automatic drive(input bit iv, input int ir, input bit [1:0] ru, input int r0, input int r1,
                         input bit wv, input int wr);
        @(negedge clk);
        issue_valid = iv;
        issue_regno = 5'(ir);
        rd_use      = ru;
        rd_regno    = {5'(r1), 5'(r0)};
        wb_valid    = wv;
        wb_regno    = 5'(wr);
    endtask

    task automatic idle();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0, 0);
    endtask

    int pool [5] = '{0, 5, 7, 9, 12};

    function automatic int pick();
        if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 31));
        return pool[$urandom_range(0, 4)];
    endfunction

    initial begin
        check_en = 1'b1;
        // Reset held with random inputs
        repeat (4) drive(1'($urandom_range(0, 1)), pick(), 2'($urandom_range(0, 3)), pick(), pick(),
                         1'($urandom_range(0, 1)), pick());
        #2;
        chk("rst_pending", pending, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_stall", stall, 0);
        chk("rst_underflow", underflow_err, 0);
        @(negedge clk);
        reset = 1'b1;
        idle();

        // Issue x5, read it, then release it
        drive(1'b1, 5, 2'b00, 0, 0, 1'b0, 0);  #2 chk("t2_fire", issue_fire, 1);
        drive(1'b0, 0, 2'b01, 5, 0, 1'b0, 0);  #2 chk("t2_hazard", hazard, 1);
        chk("t2_pending5", pending[5], 1);
        drive(1'b0, 0, 2'b01, 5, 0, 1'b1, 5);  #2 chk("t2_wb_cycle_hazard", hazard, BYP ? 0 : 1);
        drive(1'b0, 0, 2'b01, 5, 0, 1'b0, 0);  #2 chk("t2_after_wb_hazard", hazard, 0);

        // Saturate x7
        repeat (3) begin
            drive(1'b1, 7, 2'b00, 0, 0, 1'b0, 0); #2 chk("t3_fire", issue_fire, 1);
        end
        drive(1'b1, 7, 2'b00, 0, 0, 1'b0, 0);  #2 chk("t3_outstanding3", outstanding, 3);
        chk("t3_sat", sat_stall, 1);
        chk("t3_nofire", issue_fire, 0);
        drive(1'b0, 0, 2'b00, 0, 0, 1'b1, 7);
        drive(1'b1, 7, 2'b00, 0, 0, 1'b0, 0);  #2 chk("t3_refire", issue_fire, 1);
        idle();                                #2 chk("t3_back_to_3", outstanding, 3);
        repeat (3) drive(1'b0, 0, 2'b00, 0, 0, 1'b1, 7);

        // Issue and release x9 together
        drive(1'b1, 9, 2'b00, 0, 0, 1'b0, 0);
        drive(1'b1, 9, 2'b00, 0, 0, 1'b1, 9);  #2 chk("t4_fire", issue_fire, 1);
        idle();                                #2 chk("t4_pending9", pending[9], 1);
        chk("t4_outstanding", outstanding, 1);
        drive(1'b0, 0, 2'b00, 0, 0, 1'b1, 9);

        // Register 0
        drive(1'b1, 0, 2'b11, 0, 0, 1'b0, 0);  #2 chk("t5_fire", issue_fire, 1);
        chk("t5_hazard", hazard, 0);
        drive(1'b0, 0, 2'b00, 0, 0, 1'b1, 0);  #2 chk("t5_pending", pending, 0);
        chk("t5_outstanding", outstanding, 0);
        idle();                                #2 chk("t5_underflow", underflow_err, 0);

        // Underflow on x12
        drive(1'b0, 0, 2'b00, 0, 0, 1'b1, 12);
        idle();                                #2 chk("t6_underflow", underflow_err, 1);
        chk("t6_outstanding", outstanding, 0);
        idle();                                #2 chk("t6_sticky", underflow_err, 1);
        @(negedge clk);
        reset = 1'b0;
        #2 chk("t6_reset_clears", underflow_err, 0);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic with occasional mid-run reset
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), pick(), 2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 2) == 0), pick());
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            else reset = 1'b1;
        end
        reset = 1'b1;
        idle();
        idle();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
